pb_mem_tile_spm_ctrl: RTL and testbench

Request/response front-end that sits directly upstream of the L2 SPM macro in every Picobello mem tile. It consumes decoded narrow requests from the tile's NoC chimney side and drives a fixed-latency SRAM port. It range-checks each request against the tile's window; its size is the mem tile size from picobello_pkg. Responses return strictly in request order, and the block sustains one request per cycle.

---
 rtl/pb_mem_tile_spm_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pb_mem_tile_spm_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_mem_tile_spm_ctrl.sv
// SPM front-end for a Picobello mem tile: range-checks narrow requests, drives a fixed-latency
// SRAM port and returns in-order responses through a small credit-guarded fall-through FIFO.
module pb_mem_tile_spm_ctrl #(
  parameter int unsigned          AddrWidth     = 48,
  parameter int unsigned          DataWidth     = 64,
  parameter int unsigned          StrbWidth     = DataWidth / 8,
  parameter logic [AddrWidth-1:0] BaseAddr      = '0,
  parameter int unsigned          MemSize       = 32'h0010_0000,
  parameter int unsigned          SramLatency   = 1,
  parameter int unsigned          SramAddrWidth = $clog2(MemSize / StrbWidth)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [AddrWidth-1:0]     req_addr_i,
  input  logic                     req_write_i,
  input  logic [DataWidth-1:0]     req_wdata_i,
  input  logic [StrbWidth-1:0]     req_strb_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DataWidth-1:0]     rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [SramAddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0]     sram_wdata_o,
  output logic [StrbWidth-1:0]     sram_be_o,
  input  logic [DataWidth-1:0]     sram_rdata_i
);

  localparam int unsigned Depth        = SramLatency + 1;
  localparam int unsigned OffBits      = $clog2(StrbWidth);
  localparam int unsigned MemBits      = $clog2(MemSize);
  localparam int unsigned CntWidth     = $clog2(SramLatency + 2);
  localparam int unsigned FifoCntWidth = $clog2(Depth + 1);
  localparam logic [AddrWidth:0] WinLo = {1'b0, BaseAddr};
  localparam logic [AddrWidth:0] WinHi = WinLo + (AddrWidth + 1)'(MemSize);
  localparam logic [CntWidth-1:0] MaxInflight = CntWidth'(SramLatency + 1);

  typedef struct packed {
    logic                 err;
    logic [DataWidth-1:0] rdata;
  } entry_t;

  logic                   in_range, accept, pop, push;
  logic [MemBits-1:0]     offset;
  logic                   unused_offset;
  logic [SramLatency-1:0] pipe_valid_q, pipe_valid_d;
  logic [SramLatency-1:0] pipe_err_q, pipe_err_d;
  logic [SramLatency-1:0] pipe_write_q, pipe_write_d;
  entry_t                 push_entry, head;
  entry_t                 fifo_q [Depth];
  entry_t                 fifo_d [Depth];
  logic [FifoCntWidth-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CntWidth-1:0]    inflight_q, inflight_d;

  // Upper bound compared one bit wider so BaseAddr + MemSize cannot wrap.
  assign in_range = ({1'b0, req_addr_i} >= WinLo) && ({1'b0, req_addr_i} < WinHi);
  assign offset   = req_addr_i[MemBits-1:0] - BaseAddr[MemBits-1:0];
  assign unused_offset = ^offset[OffBits-1:0];

  assign pop         = rsp_valid_o && rsp_ready_i;
  assign req_ready_o = (inflight_q < MaxInflight) || pop;
  assign accept      = req_valid_i && req_ready_o && !rst_i;

  assign sram_req_o   = accept && in_range;
  assign sram_we_o    = sram_req_o && req_write_i;
  assign sram_addr_o  = sram_req_o ? offset[MemBits-1:OffBits] : '0;
  assign sram_wdata_o = sram_req_o ? req_wdata_i : '0;
  assign sram_be_o    = sram_req_o ? req_strb_i : '0;

  always_comb begin
    pipe_valid_d    = '0;
    pipe_err_d      = '0;
    pipe_write_d    = '0;
    pipe_valid_d[0] = accept;
    pipe_err_d[0]   = !in_range;
    pipe_write_d[0] = req_write_i;
    for (int i = 1; i < SramLatency; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_err_d[i]   = pipe_err_q[i-1];
      pipe_write_d[i] = pipe_write_q[i-1];
    end
  end

  assign push = pipe_valid_q[SramLatency-1];

  always_comb begin
    push_entry       = '0;
    push_entry.err   = push && pipe_err_q[SramLatency-1];
    if (push && !pipe_err_q[SramLatency-1] && !pipe_write_q[SramLatency-1]) begin
      push_entry.rdata = sram_rdata_i;
    end
  end

  // An empty FIFO passes the arriving entry straight through to the response port.
  assign head        = (fifo_cnt_q != '0) ? fifo_q[0] : push_entry;
  assign rsp_valid_o = (fifo_cnt_q != '0) || push;
  assign rsp_rdata_o = head.rdata;
  assign rsp_err_o   = head.err;

  always_comb begin
    fifo_d     = fifo_q;
    fifo_cnt_d = fifo_cnt_q;
    if (pop && fifo_cnt_q != '0) begin
      for (int i = 0; i < Depth - 1; i++) fifo_d[i] = fifo_q[i+1];
      fifo_cnt_d = fifo_cnt_q - 1'b1;
    end
    if (push && !(pop && fifo_cnt_q == '0)) begin
      for (int i = 0; i < Depth; i++) begin
        if (FifoCntWidth'(i) == fifo_cnt_d) fifo_d[i] = push_entry;
      end
      fifo_cnt_d = fifo_cnt_d + 1'b1;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !pop) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!accept && pop) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid_q <= '0;
      pipe_err_q   <= '0;
      pipe_write_q <= '0;
      fifo_q       <= '{default: '0};
      fifo_cnt_q   <= '0;
      inflight_q   <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_err_q   <= pipe_err_d;
      pipe_write_q <= pipe_write_d;
      fifo_q       <= fifo_d;
      fifo_cnt_q   <= fifo_cnt_d;
      inflight_q   <= inflight_d;
    end
  end

  logic   hold_q;
  entry_t held_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q <= 1'b0;
      held_q <= '0;
    end else begin
      hold_q <= rsp_valid_o && !rsp_ready_i;
      held_q <= head;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ((MemSize & (MemSize - 1)) == 0 && MemSize >= StrbWidth);
      assert (SramLatency inside {32'd1, 32'd2});
      assert (!(push && !pop && fifo_cnt_q == FifoCntWidth'(Depth)));
      assert (!hold_q || (rsp_valid_o && head == held_q));
    end
  end

endmodule

// File: tb/tb_pb_mem_tile_spm_ctrl.sv
// Directed bench for pb_mem_tile_spm_ctrl: a latency-1 instance for the main tests and a
// latency-2 instance for backpressure, both checked against a scoreboard of expected responses.
module tb_pb_mem_tile_spm_ctrl;

  localparam int unsigned MS      = 32'h0010_0000;
  localparam logic [47:0] BASE    = 48'h7000_0000;
  localparam logic [63:0] GARBAGE = 64'hBADC_0FFE_E0DD_F00D;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic        sram_req, sram_we;
  logic [47:0] req_addr;
  logic [63:0] req_wdata, rsp_rdata, sram_wdata, sram_rdata;
  logic [7:0]  req_strb, sram_be;
  logic [16:0] sram_addr;

  logic        req_valid2, req_ready2, req_write2, rsp_valid2, rsp_ready2, rsp_err2;
  logic        sram_req2, sram_we2;
  logic [47:0] req_addr2;
  logic [63:0] req_wdata2, rsp_rdata2, sram_wdata2, sram_rdata2, rd2a;
  logic [7:0]  req_strb2, sram_be2;
  logic [16:0] sram_addr2;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   strobes = 0;
  int   rsp2_count = 0;
  bit   lat_check = 1'b0;
  exp_t sb[$];
  exp_t sb2[$];
  logic [63:0] sram1 [0:(1<<17)-1];
  logic [63:0] refm  [0:(1<<17)-1];

  pb_mem_tile_spm_ctrl #(
    .BaseAddr(BASE), .MemSize(MS), .SramLatency(1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  pb_mem_tile_spm_ctrl #(
    .BaseAddr(BASE), .MemSize(MS), .SramLatency(2)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_addr_i(req_addr2),
    .req_write_i(req_write2), .req_wdata_i(req_wdata2), .req_strb_i(req_strb2),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_rdata_o(rsp_rdata2),
    .rsp_err_o(rsp_err2),
    .sram_req_o(sram_req2), .sram_we_o(sram_we2), .sram_addr_o(sram_addr2),
    .sram_wdata_o(sram_wdata2), .sram_be_o(sram_be2), .sram_rdata_i(sram_rdata2)
  );

  function automatic logic [63:0] init_word(input logic [16:0] idx);
    logic [31:0] w;
    w = {15'd0, idx};
    return {w ^ 32'hC0DE_0000, ~w};
  endfunction

  function automatic logic in_win(input logic [47:0] a);
    return (a >= BASE) && (a < BASE + 48'(MS));
  endfunction

  function automatic logic [16:0] word_idx(input logic [47:0] a);
    logic [47:0] off;
    off = a - BASE;
    return off[19:3];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SRAM macro models: latency 1 with byte-enabled writes, and latency 2 read-only.
  always @(posedge clk) begin
    if (sram_req && sram_we) begin
      for (int b = 0; b < 8; b++) begin
        if (sram_be[b]) sram1[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
      end
    end
    sram_rdata <= (sram_req && !sram_we) ? sram1[sram_addr] : GARBAGE;
    rd2a        <= (sram_req2 && !sram_we2) ? init_word(sram_addr2) : GARBAGE;
    sram_rdata2 <= rd2a;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    exp_t        e;
    logic        inr;
    logic [16:0] idx;
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 64'(rsp_err), 64'(e.err));
          if (lat_check) check("rsp_latency", 64'(cyc - e.cyc), 64'd1);
        end
      end
      if (req_valid && req_ready) begin
        inr = in_win(req_addr);
        idx = word_idx(req_addr);
        check("sram_req", 64'(sram_req), 64'(inr));
        if (inr) begin
          check("sram_addr", 64'(sram_addr), 64'(idx));
          check("sram_we", 64'(sram_we), 64'(req_write));
          if (req_write) begin
            for (int b = 0; b < 8; b++) begin
              if (req_strb[b]) refm[idx][8*b +: 8] = req_wdata[8*b +: 8];
            end
          end
        end
        e.err   = !inr;
        e.rdata = (inr && !req_write) ? refm[idx] : 64'd0;
        e.cyc   = cyc;
        sb.push_back(e);
      end else begin
        check("sram_req_idle", 64'(sram_req), 64'd0);
      end
      if (sram_req) strobes++;

      if (rsp_valid2 && rsp_ready2) begin
        if (sb2.size() == 0) begin
          check("rsp2_unexpected", 64'(rsp_valid2), 64'd0);
        end else begin
          e = sb2.pop_front();
          rsp2_count++;
          check("rsp2_rdata", rsp_rdata2, e.rdata);
          check("rsp2_err", 64'(rsp_err2), 64'(e.err));
        end
      end
      if (req_valid2 && req_ready2) begin
        inr = in_win(req_addr2);
        idx = word_idx(req_addr2);
        check("sram2_req", 64'(sram_req2), 64'(inr));
        e.err   = !inr;
        e.rdata = inr ? init_word(idx) : 64'd0;
        e.cyc   = cyc;
        sb2.push_back(e);
      end
    end
  end

  task automatic send(input logic [47:0] a, input logic w, input logic [63:0] d,
                      input logic [7:0] s, output int waits);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    req_strb  = s;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("send_timeout", 64'(req_ready), 64'd1);
    waits = n;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_wdata = '0;
    req_strb  = '0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int total_waits;
    int acc;
    logic got;
    for (int i = 0; i < (1 << 17); i++) begin
      sram1[i] = init_word(17'(i));
      refm[i]  = init_word(17'(i));
    end
    req_valid = 0; req_addr = '0; req_write = 0; req_wdata = '0; req_strb = '0;
    req_valid2 = 0; req_addr2 = '0; req_write2 = 0; req_wdata2 = '0; req_strb2 = '0;
    rsp_ready = 1; rsp_ready2 = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    check("reset_rsp_err", 64'(rsp_err), 64'd0);
    check("reset_sram_req", 64'(sram_req), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_valid2", 64'(rsp_valid2), 64'd0);
    rst = 0;
    @(posedge clk);
    #1;
    lat_check = 1;

    // Write then read back the same word.
    send(BASE + 48'h10, 1'b1, 64'hDEAD_BEEF_0000_1111, 8'hFF, w);
    send(BASE + 48'h10, 1'b0, '0, 8'h00, w);
    drain();
    check("t1_ref_word", refm[2], 64'hDEAD_BEEF_0000_1111);

    // Just past the window and just below it.
    strobes = 0;
    send(BASE + 48'h10_0000, 1'b0, '0, 8'h00, w);
    send(48'h6FFF_FFF8, 1'b0, '0, 8'h00, w);
    drain();
    check("t2_strobes", 64'(strobes), 64'd0);

    total_waits = 0;
    for (int i = 0; i < 8; i++) begin
      send(BASE + 48'h1000 + 48'(i * 8), 1'b0, '0, 8'h00, w);
      total_waits += w;
    end
    drain();
    check("t3_ready_stalls", 64'(total_waits), 64'd0);
    check("t3_drained", 64'(sb.size()), 64'd0);

    // Backpressure on the latency-2 instance.
    rsp_ready2 = 0;
    req_valid2 = 1;
    req_addr2  = BASE + 48'h200;
    acc = 0;
    repeat (6) begin
      @(negedge clk);
      got = req_ready2;
      @(posedge clk);
      #1;
      if (got) begin
        acc++;
        req_addr2 += 48'd8;
      end
    end
    check("t4_accepts", 64'(acc), 64'd3);
    check("t4_ready_low", 64'(req_ready2), 64'd0);
    rsp_ready2 = 1;
    @(negedge clk);
    check("t4_pop_and_accept", 64'({rsp_valid2, req_ready2}), 64'd3);
    @(posedge clk);
    #1;
    req_valid2 = 0;
    repeat (8) @(posedge clk);
    #1;
    check("t4_drained", 64'(sb2.size()), 64'd0);
    check("t4_rsp_count", 64'(rsp2_count), 64'd4);

    strobes = 0;
    send(BASE + 48'h10, 1'b0, '0, 8'h00, w);
    send(BASE + 48'h20_0000, 1'b0, '0, 8'h00, w);
    send(BASE + 48'h18, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h0F, w);
    drain();
    check("t5_strobes", 64'(strobes), 64'd2);
    check("t5_drained", 64'(sb.size()), 64'd0);

    // Reset with two responses held in the FIFO.
    lat_check = 0;
    rsp_ready = 0;
    send(BASE + 48'h10, 1'b0, '0, 8'h00, w);
    send(BASE + 48'h18, 1'b0, '0, 8'h00, w);
    @(negedge clk);
    check("t6_pending", 64'(rsp_valid), 64'd1);
    #2;
    rst = 1;
    #1;
    check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("t6_rst_rsp_rdata", rsp_rdata, 64'd0);
    check("t6_rst_sram_req", 64'(sram_req), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 0;
    rsp_ready = 1;
    #1;
    check("t6_req_ready", 64'(req_ready), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check("t6_no_stale", 64'(rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    lat_check = 1;
    send(BASE + 48'h10, 1'b0, '0, 8'h00, w);
    drain();
    check("t6_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
